// File: rtl/alu_if.sv
// Operand/op request and result/flag response channels of the sequential ALU.
interface alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, overflow, negative
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, carry, zero, overflow, negative
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops plus a shift-add MUL
// that takes WIDTH cycles. Results and flags are registered and held in HOLD.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_SBB = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state;
  logic               c_reg;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q, zero_q, ovf_q, neg_q;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               accept, is_mul;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;

  assign bus.in_ready  = (state == IDLE) || (state == HOLD && bus.out_ready);
  assign bus.out_valid = (state == HOLD);
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.negative  = neg_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_mul  = (MUL_EN != 0) && (bus.op == OP_MUL);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle datapath; ADC/SBB fold in the carry register as it stands at accept.
  always_comb begin
    ext   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, (bus.op == OP_ADC) && c_reg};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (bus.a[MSB] == bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_SBB: begin
        ext   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, (bus.op == OP_SBB) && c_reg};
        alu_r = ext[MSB:0];
        alu_c = ext[WIDTH];
        alu_v = (bus.a[MSB] != bus.b[MSB]) && (alu_r[MSB] != bus.a[MSB]);
      end
      OP_AND: alu_r = bus.a & bus.b;
      OP_OR:  alu_r = bus.a | bus.b;
      OP_XOR: alu_r = bus.a ^ bus.b;
      OP_NOT: alu_r = ~bus.a;
      OP_SHL: begin
        alu_r = {bus.a[MSB-1:0], 1'b0};
        alu_c = bus.a[MSB];
      end
      OP_SHR: begin
        alu_r = {1'b0, bus.a[MSB:1]};
        alu_c = bus.a[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      c_reg   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state  <= BUSY;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              cnt    <= '0;
            end else begin
              state   <= HOLD;
              res_q   <= alu_r;
              carry_q <= alu_c;
              ovf_q   <= alu_v;
              zero_q  <= (alu_r == '0);
              neg_q   <= alu_r[MSB];
              c_reg   <= alu_c;
            end
          end else if (state == HOLD && bus.out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Last partial product: acc_nxt already holds the full 2*WIDTH-bit product.
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= HOLD;
            res_q   <= acc_nxt[MSB:0];
            carry_q <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
            zero_q  <= (acc_nxt[MSB:0] == '0);
            neg_q   <= acc_nxt[MSB];
            c_reg   <= |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8), .MUL_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] r, input logic c, input logic z,
                         input logic v, input logic n);
    chk({tag, ".valid"}, bus.out_valid, 1'b1);
    chk({tag, ".result"}, bus.result, r);
    chk({tag, ".carry"}, bus.carry, c);
    chk({tag, ".zero"}, bus.zero, z);
    chk({tag, ".ovf"}, bus.overflow, v);
    chk({tag, ".neg"}, bus.negative, n);
  endtask

  initial begin
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;

    // Reset state
    step();
    chk("rst.valid", bus.out_valid, 1'b0);
    chk("rst.ready", bus.in_ready, 1'b1);
    chk("rst.result", bus.result, 8'h00);
    chk("rst.flags", {bus.carry, bus.zero, bus.overflow, bus.negative}, 4'b0000);

    // ADD 7F+01: signed overflow, accepted on the first edge after reset release
    rst = 1'b0;
    drive(1'b1, 4'd0, 8'h7F, 8'h01);
    step();
    chk_out("add7f", 8'h80, 1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b1);
    chk("add7f.ready", bus.in_ready, 1'b1);

    // Back-to-back ADD FF+01 then ADC 00+00 using the carry just produced
    drive(1'b1, 4'd0, 8'hFF, 8'h01);
    step();
    chk_out("addff", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'd8, 8'h00, 8'h00);
    step();
    chk_out("adc", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    step();
    chk("idle.valid", bus.out_valid, 1'b0);

    // SUB 00-01 borrow, then SHR 01
    drive(1'b1, 4'd1, 8'h00, 8'h01);
    step();
    chk_out("sub", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'd7, 8'h01, 8'h00);
    step();
    chk_out("shr", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // SBB 05-02-C(=1) and SUB 80-01 signed overflow
    drive(1'b1, 4'd9, 8'h05, 8'h02);
    step();
    chk_out("sbb", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd1, 8'h80, 8'h01);
    step();
    chk_out("sub80", 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 4'd6, 8'hC3, 8'h00);
    step();
    chk_out("shl", 8'h86, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'd4, 8'hF0, 8'h3C);
    step();
    chk_out("xor", 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    step();

    // MUL 10*11: eight busy cycles, operand changes ignored
    drive(1'b1, 4'd10, 8'h10, 8'h11);
    step();
    drive(1'b1, 4'd0, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk("mul.busy_ready", bus.in_ready, 1'b0);
      chk("mul.busy_valid", bus.out_valid, 1'b0);
      step();
    end
    chk_out("mul", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: result held stable for 5 cycles, new request ignored
    bus.out_ready = 1'b0;
    drive(1'b1, 4'd0, 8'h01, 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("hold", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("hold.ready", bus.in_ready, 1'b0);
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    step();
    chk("drain.valid", bus.out_valid, 1'b0);

    // Reset asserted in the 4th busy cycle of a MUL aborts it immediately
    drive(1'b1, 4'd10, 8'h03, 8'h05);
    step();
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("abort.valid", bus.out_valid, 1'b0);
    chk("abort.ready", bus.in_ready, 1'b1);
    chk("abort.result", bus.result, 8'h00);
    chk("abort.flags", {bus.carry, bus.zero, bus.overflow, bus.negative}, 4'b0000);
    step();
    chk("abort.held", bus.out_valid, 1'b0);

    // Undefined op 12 right after reset release
    rst = 1'b0;
    drive(1'b1, 4'd12, 8'h05, 8'h03);
    step();
    chk_out("undef", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset cleared C: ADC 00+00 yields 0
    drive(1'b1, 4'd8, 8'h00, 8'h00);
    step();
    chk_out("adc0", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 8'h00, 8'h00);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, as the operand and result width in bits; legal range 4..32.
REQ-002 The block SHALL expose parameter MUL_EN, default 1; 1 enables the multi-cycle MUL op, 0 makes MUL behave as an undefined op.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand/op bundle is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts the bundle this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port op, input, 4 bits: operation select.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result bundle is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port result, output, WIDTH bits: registered result.
REQ-013 The block SHALL have port carry, output, 1 bit: registered carry/borrow flag.
REQ-014 The block SHALL have port zero, output, 1 bit: registered zero flag.
REQ-015 The block SHALL have port overflow, output, 1 bit: registered signed-overflow flag.
REQ-016 The block SHALL have port negative, output, 1 bit: registered sign flag.

Function
REQ-017 A bundle SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 The FSM SHALL have three states: IDLE, BUSY (MUL in progress) and HOLD (result presented).
REQ-019 in_ready SHALL be 1 in IDLE, 1 in HOLD when out_ready=1, and 0 otherwise; HOLD with out_ready=1 permits back-to-back accepts.
REQ-020 out_valid SHALL be 1 exactly in HOLD; result and all flags SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Transitions: a non-MUL accept SHALL go to HOLD next cycle (latency 1); a MUL accept SHALL go to BUSY.
REQ-022 BUSY SHALL perform shift-add over exactly WIDTH cycles, then go to HOLD (latency WIDTH+1).
REQ-023 From HOLD with out_ready=1 the FSM SHALL go to IDLE, unless a new bundle is accepted the same cycle, in which case it goes to HOLD or BUSY per REQ-021.
REQ-024 Op encoding SHALL be:
  - 0 ADD: a+b
  - 1 SUB: a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: ~a
  - 6 SHL: a<<1
  - 7 SHR: logical a>>1
  - 8 ADC: a+b+C
  - 9 SBB: a-b-C
  - 10 MUL: low WIDTH bits of a*b, unsigned
  - 11..15 undefined: result 0, carry 0, overflow 0.
  C is the internal carry register.
REQ-025 The carry output SHALL be set per op:
  - ADD/ADC: carry out of bit WIDTH-1
  - SUB/SBB: unsigned borrow (1 when a < b+borrow-in)
  - SHL: a[WIDTH-1]
  - SHR: a[0]
  - MUL: 1 if any product bit at or above bit WIDTH is set
  - all other ops: 0
REQ-026 The overflow output SHALL be set per op:
  - ADD/ADC: a and b have equal MSBs and result MSB differs from a
  - SUB/SBB: a and b have differing MSBs and result MSB differs from a
  - all other ops: 0
REQ-027 The zero output SHALL be (result==0) and negative SHALL be result[WIDTH-1], for every op.
REQ-028 Internal register C SHALL load the carry value on each entry to HOLD; ADC/SBB SHALL use the C value present at the accept edge.
REQ-029 Operands SHALL be captured at accept; input changes during BUSY/HOLD SHALL have no effect.

Reset
REQ-030 While rst=1 the block SHALL hold FSM=IDLE, out_valid=0, in_ready=1, result=0, carry=zero=overflow=negative=0, C=0.
REQ-031 Assertion of rst during BUSY or HOLD SHALL abort the operation with no result delivered.
REQ-032 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-033 The bench SHALL cover these directed scenarios with WIDTH=8:
  - ADD 0x7F+0x01 -> one cycle later out_valid=1, result=0x80, overflow=1, negative=1, carry=0.
  - ADD 0xFF+0x01 then ADC 0x00+0x00 back-to-back with out_ready=1 -> results 0x00 (carry=1, zero=1) then 0x01.
  - SUB 0x00-0x01 -> result 0xFF, carry=1, overflow=0; SHR 0x01 -> result 0x00, carry=1, zero=1.
  - MUL 0x10*0x11 -> in_ready=0 for 8 cycles, out_valid on cycle 9, result=0x10, carry=1.
  - Hold out_ready=0 for 5 cycles after a result -> result/flags unchanged, in_ready=0, new in_valid ignored.
  - Assert rst mid-MUL (cycle 4) -> out_valid=0 and all outputs 0 immediately; op 12 after reset -> result 0, zero=1.
